// File: rtl/aes_ctrl_pkg.sv
// Shared types and encodings for the iterative AES round sequencer.
package aes_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } ctrl_state_e;

  localparam logic [1:0] SEL_LOAD  = 2'd0;
  localparam logic [1:0] SEL_ROUND = 2'd1;
  localparam logic [1:0] SEL_FINAL = 2'd2;

  localparam int AES128_NR = 10;

endpackage

// File: rtl/aes_round_ctrl_blk_ctr.sv
// CTR block counter: loadable, increments on every accepted block.
module blk_ctr #(
  parameter int CTR_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load_en,
  input  logic             inc_en,
  input  logic [CTR_W-1:0] init,
  output logic [CTR_W-1:0] value
);

  localparam logic [CTR_W-1:0] ONE = CTR_W'(1);

  logic [CTR_W-1:0] cnt_q;
  logic [CTR_W-1:0] cnt_d;

  // A load coinciding with an accept: the accepted block has already used the
  // old value, so the register skips straight to init+1.
  always_comb begin
    cnt_d = cnt_q;
    if (load_en) begin
      cnt_d = inc_en ? (init + ONE) : init;
    end else if (inc_en) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value = cnt_q;

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES round sequencer: LOAD, NR-1 full rounds, FINAL, then holds the
// keystream block under valid/ready; also owns the CTR block counter.
module aes_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int NR    = AES128_NR,
  parameter int CTR_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             state_we,
  output logic [1:0]       state_sel,
  output logic [3:0]       round_idx,
  output logic             busy,
  input  logic             ctr_load,
  input  logic [CTR_W-1:0] ctr_init,
  output logic [CTR_W-1:0] ctr_blk
);

  localparam logic [3:0] NR_IDX = 4'(NR);
  localparam logic [3:0] LAST_R = 4'(NR - 1);

  ctrl_state_e state_q, state_d;
  logic [3:0]  r_q, r_d;
  logic        out_valid_q;
  logic        busy_q;
  logic        accept;

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    in_ready  = 1'b0;
    state_we  = 1'b0;
    state_sel = SEL_LOAD;
    round_idx = 4'd0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_we = 1'b1;
          state_d  = ST_ROUND;
          r_d      = 4'd1;
        end
      end
      ST_ROUND: begin
        state_we  = 1'b1;
        state_sel = SEL_ROUND;
        round_idx = r_q;
        if (r_q == LAST_R) begin
          state_d = ST_FINAL;
          r_d     = 4'd0;
        end else begin
          r_d = r_q + 4'd1;
        end
      end
      ST_FINAL: begin
        state_we  = 1'b1;
        state_sel = SEL_FINAL;
        round_idx = NR_IDX;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        // The old block leaves on this edge, so a new LOAD may overwrite it.
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            state_we = 1'b1;
            state_d  = ST_ROUND;
            r_d      = 4'd1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      r_q         <= 4'd0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      out_valid_q <= (state_d == ST_DONE);
      busy_q      <= (state_d == ST_ROUND) || (state_d == ST_FINAL);
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = busy_q;

  blk_ctr #(
    .CTR_W(CTR_W)
  ) u_blk_ctr (
    .clk    (clk),
    .resetn (resetn),
    .load_en(ctr_load && ((state_q == ST_IDLE) || (state_q == ST_DONE))),
    .inc_en (accept),
    .init   (ctr_init),
    .value  (ctr_blk)
  );

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl: a transaction-level model predicts
// handshakes, state writes and counter values; a monitor checks DUT activity.
module tb_aes_round_ctrl;

  localparam int NR    = 10;
  localparam int CTR_W = 32;

  logic             clk = 1'b0;
  logic             resetn;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic             state_we, busy, ctr_load;
  logic [1:0]       state_sel;
  logic [3:0]       round_idx;
  logic [CTR_W-1:0] ctr_init, ctr_blk;

  aes_round_ctrl #(.NR(NR), .CTR_W(CTR_W)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .state_we (state_we),
    .state_sel(state_sel),
    .round_idx(round_idx),
    .busy     (busy),
    .ctr_load (ctr_load),
    .ctr_init (ctr_init),
    .ctr_blk  (ctr_blk)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [1:0] sel;
    logic [3:0] idx;
  } wr_t;

  typedef struct {
    logic [CTR_W-1:0] ctr;
    int               out_cyc;
  } blk_t;

  wr_t              wq[$];
  blk_t             bq[$];
  logic [CTR_W-1:0] oq[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_state_we"}, state_we, 0);
    chk({tag, "_state_sel"}, state_sel, 0);
    chk({tag, "_round_idx"}, round_idx, 0);
    chk({tag, "_ctr_blk"}, ctr_blk, 0);
  endtask

  // Reference model: a block occupies NR busy cycles after its accept cycle,
  // then waits in a done phase until consumed.
  int               m_rem  = 0;
  bit               m_done = 0;
  logic [CTR_W-1:0] m_ctr  = '0;

  always @(negedge clk) begin
    bit  exp_ready, acc;
    wr_t w;
    if (!resetn) begin
      m_rem  = 0;
      m_done = 0;
      m_ctr  = '0;
      wq.delete();
      bq.delete();
    end else begin
      exp_ready = (m_rem == 0) && (!m_done || out_ready);
      chk("in_ready", in_ready, exp_ready);
      chk("out_valid", out_valid, m_done);
      chk("busy", busy, m_rem > 0);
      chk("ctr_blk", ctr_blk, m_ctr);
      acc = in_valid && exp_ready;
      if (acc) begin
        bq.push_back('{ctr: m_ctr, out_cyc: cyc + NR + 1});
        for (int k = 0; k <= NR; k++) begin
          w.cyc = cyc + k;
          w.sel = (k == 0) ? 2'd0 : ((k == NR) ? 2'd2 : 2'd1);
          w.idx = 4'(k);
          wq.push_back(w);
        end
      end
      if (ctr_load && m_rem == 0) m_ctr = acc ? ctr_init + 1 : ctr_init;
      else if (acc) m_ctr = m_ctr + 1;
      if (acc) begin
        m_rem  = NR;
        m_done = 0;
      end else if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) m_done = 1;
      end else if (m_done && out_ready) begin
        m_done = 0;
      end
    end
  end

  // Monitor: consumes expectations whenever the DUT writes state or presents output.
  bit ov_seen = 0;

  always @(negedge clk) begin
    wr_t              e;
    blk_t             b;
    logic [CTR_W-1:0] o;
    #1;
    if (!resetn) begin
      oq.delete();
      ov_seen = 0;
    end else begin
      if (state_we) begin
        chk("we_expected", wq.size() > 0, 1);
        if (wq.size() > 0) begin
          e = wq.pop_front();
          chk("we_cycle", cyc, e.cyc);
          chk("we_sel", state_sel, e.sel);
          chk("we_idx", round_idx, e.idx);
        end
      end
      if (in_valid && in_ready) oq.push_back(ctr_blk);
      if (out_valid && !ov_seen) begin
        ov_seen = 1;
        chk("ov_expected", bq.size() > 0, 1);
        if (bq.size() > 0) chk("ov_latency", cyc, bq[0].out_cyc);
      end
      if (out_valid && out_ready) begin
        chk("blk_pending", (bq.size() > 0) && (oq.size() > 0), 1);
        if (bq.size() > 0 && oq.size() > 0) begin
          b = bq.pop_front();
          o = oq.pop_front();
          chk("blk_ctr_used", o, b.ctr);
        end
        ov_seen = 0;
      end
    end
  end

  initial begin
    resetn    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ctr_load  = 1'b0;
    ctr_init  = '0;
    #12;
    check_reset("por");
    #11 resetn = 1'b1;
    step();
    chk("por_in_ready", in_ready, 1);
    step();

    // Single block, then hold it in DONE with out_ready low and in_valid high.
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("single_ctr", ctr_blk, 1);
    for (int i = 0; i < 40 && !out_valid; i++) step();
    chk("single_done", out_valid, 1);
    in_valid = 1'b1;
    repeat (5) step();
    chk("hold_valid", out_valid, 1);
    chk("hold_ctr", ctr_blk, 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();

    // Counter wrap.
    ctr_load = 1'b1;
    ctr_init = 32'hFFFF_FFFF;
    step();
    ctr_load  = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    chk("wrap_ctr", ctr_blk, 0);
    repeat (NR + 3) step();

    // Continuous traffic: one accept every NR+1 cycles.
    in_valid = 1'b1;
    repeat (3 * (NR + 1)) step();
    in_valid = 1'b0;
    chk("cont_ctr", ctr_blk, 3);
    repeat (NR + 3) step();

    // Load simultaneous with accept, then a load during ROUND.
    ctr_load = 1'b1;
    ctr_init = 32'h10;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("load_acc_ctr", ctr_blk, 32'h11);
    ctr_init = 32'h55;
    step();
    ctr_load = 1'b0;
    chk("load_ignored", ctr_blk, 32'h11);
    repeat (NR + 3) step();

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      ctr_load  = ($urandom_range(0, 15) == 0);
      ctr_init  = $urandom;
      step();
    end
    in_valid  = 1'b0;
    ctr_load  = 1'b0;
    out_ready = 1'b1;
    repeat (NR + 4) step();

    // Reset in the middle of round 5.
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("pre_rst_idx", round_idx, 5);
    #2 resetn = 1'b0;
    #1 check_reset("mid");
    #3 resetn = 1'b1;
    step();
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_ctr", ctr_blk, 0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (NR + 4) step();

    chk("wq_drained", wq.size(), 0);
    chk("bq_drained", bq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Iterative-AES sequencer for the CTR encryption core. It accepts one counter block per handshake and drives the 128-bit state register's write enable and datapath mux select. It steps the round-key index through the initial AddRoundKey, NR-1 full rounds and the final round, then holds the result under a valid/ready output handshake. It also owns the 32-bit CTR block counter that upstream logic concatenates with the nonce to form each input block.

## Interface
- NR, 10: number of AES rounds; 10 for AES-128, legal range 2..14.
- CTR_W, 32: width of the block counter.
- clk  in  1  rising-edge clock; single clock domain.
- resetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  input block (nonce‖ctr_blk) present on the datapath.
- in_ready  out  1  controller can accept a block.
- out_valid  out  1  state register holds a finished keystream block.
- out_ready  in  1  downstream consumes the keystream block.
- state_we  out  1  active-high write enable to the state register.
- state_sel  out  2  datapath mux select: 0 LOAD (input XOR key0), 1 ROUND (full round), 2 FINAL (no MixColumns), 3 unused.
- round_idx  out  4  round-key index presented to the key store, 0..NR.
- busy  out  1  high in ROUND or FINAL.
- ctr_load  in  1  load the block counter from ctr_init.
- ctr_init  in  CTR_W  counter load value.
- ctr_blk  out  CTR_W  current block counter value.

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - ROUND: round r = 1..NR-1.
  - FINAL: round NR.
  - DONE: out_valid=1.
- IDLE:
  - on in_valid: state_we=1, state_sel=LOAD, round_idx=0, then go to ROUND with r=1.
  - state_sel and round_idx are combinational from state, r and the accept condition.
- ROUND:
  - each cycle state_we=1, state_sel=ROUND, round_idx=r, then r++.
  - when r=NR-1 the next state is FINAL.
- FINAL: state_we=1, state_sel=FINAL, round_idx=NR, then go to DONE.
- DONE:
  - state_we=0; out_valid=1 is held until out_ready.
  - out_ready=1 with in_valid=0: go to IDLE.
  - out_ready=1 with in_valid=1: in_ready=1 in the same cycle. The controller performs the LOAD for the new block, since state_we may overwrite because the old block is consumed this edge, then goes to ROUND with r=1.
- Block counter:
  - ctr_blk increments by 1 on every input accept (in_valid && in_ready).
  - it wraps from 2^CTR_W-1 to 0 with no flag.
- ctr_load:
  - honoured only when in IDLE or DONE; ignored in ROUND and FINAL.
  - if simultaneous with an accept, the accepted block uses the old ctr_blk and the register takes ctr_init+1.
  - upstream must sample ctr_blk only while the controller is idle.
- in_valid outside IDLE/DONE is ignored; no block is lost, because in_ready is low then.
- state_we is never asserted in DONE unless the handoff is taken.

## Timing
- Reset (async, immediate) values:
  - FSM=IDLE, r=0, ctr_blk=0.
  - out_valid=0, busy=0, state_we=0, state_sel=0, round_idx=0.
  - in_ready=1 once resetn is deasserted.
- Accept at edge T:
  - LOAD is written at T.
  - rounds 1..NR-1 are written at T+1..T+NR-1.
  - FINAL is written at T+NR.
  - out_valid=1 from T+NR (after that edge) onward.
- Latency accept→out_valid: NR+1 cycles (11 for AES-128).
- Back-to-back throughput: one block per NR+1 cycles when out_ready is held high.
- Reset mid-round: the block is discarded and out_valid drops asynchronously. The state register is reset separately by the same resetn.
- All outputs except in_ready, state_we, state_sel and round_idx are registered.

## Structure
- Package aes_ctrl_pkg:
  - FSM state enum.
  - state_sel encodings SEL_LOAD/SEL_ROUND/SEL_FINAL.
  - AES128_NR=10.
- One sub-module, blk_ctr: CTR_W-bit counter with load, increment and the load-vs-increment priority rule.
- The round counter r stays inline in the FSM.

## Test plan
- Reset, then one block (in_valid for 1 cycle):
  - state_sel sequence is 0, 1×9, 2.
  - round_idx runs 0..10.
  - out_valid rises 11 cycles after accept.
  - ctr_blk goes 0→1.
- out_ready held low for 5 cycles in DONE: out_valid stays 1, state_we stays 0, and in_valid is not accepted.
- Continuous in_valid and out_ready:
  - an accept every 11 cycles, with handoff in the same cycle as consume.
  - ctr_blk goes 0→1→2→3 over 3 blocks.
- ctr_load with ctr_init=0xFFFFFFFF in IDLE, then accept: the next accept wraps ctr_blk to 0x00000000.
- ctr_load=1 with ctr_init=0x10 simultaneous with accept: ctr_blk=0x11 after the edge. ctr_load during ROUND is ignored.
- resetn pulsed low at round 5: all outputs return to reset values immediately, and after release in_ready=1 and ctr_blk=0.
